// File: rtl/bram_pkg.sv
// Shared Bram geometry and request payload, common to the Bram, its initiators and their benches.
package bram_pkg;

    localparam int unsigned BRAM_ADDR_WIDTH   = 9;
    localparam int unsigned BRAM_DATA_WIDTH   = 32;
    localparam int unsigned BRAM_READ_LATENCY = 1;

    typedef struct packed {
        logic                       write;
        logic [BRAM_ADDR_WIDTH-1:0] address;
        logic [BRAM_DATA_WIDTH-1:0] data;
    } bram_req_t;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding Bram read responses until the client takes them.
module bram_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [DATA_WIDTH-1:0]      i_push_data,
    input  logic                       i_pop,
    output logic [DATA_WIDTH-1:0]      o_head_c,
    output logic                       o_valid_c,
    output logic [$clog2(RSP_DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_pop;

    assign o_valid_c = (r_count != '0);
    assign w_pop     = i_pop & o_valid_c;
    assign o_head_c  = o_valid_c ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(i_push && !w_pop && (r_count == CNT_W'(RSP_DEPTH))));
            assert (!(i_pop && !o_valid_c));
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_port_master.sv
// Bram initiator: turns a valid/ready request stream into registered Bram pin activity and
// returns read data in order on a valid/ready response stream, with credit-based backpressure.
module bram_port_master
    import bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = BRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = BRAM_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = BRAM_READ_LATENCY,
    parameter int unsigned RSP_DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_enable,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] output_data
);

    localparam int unsigned CRED_W = $clog2(RSP_DEPTH) + 1;

    logic                  r_ram_enable;
    logic                  r_write_enable;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_input_data;
    logic [READ_LATENCY:0] r_tag;
    logic [CRED_W-1:0]     r_credit;

    logic                  w_accept;
    logic                  w_rd_accept;
    logic                  w_pop;
    logic                  w_capture;
    logic [CRED_W-1:0]     w_fifo_count;

    // Ready depends only on registered credit state and reset, never on request/response inputs.
    assign req_ready   = ~reset & (r_credit < CRED_W'(RSP_DEPTH));
    assign w_accept    = req_valid & req_ready;
    assign w_rd_accept = w_accept & ~req_write;
    assign w_pop       = rsp_valid & rsp_ready;
    assign w_capture   = r_tag[READ_LATENCY];

    assign ram_enable   = r_ram_enable;
    assign write_enable = r_write_enable;
    assign address      = r_address;
    assign input_data   = r_input_data;

    // Issue register: Bram pins carry the request accepted on the previous edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ram_enable   <= 1'b0;
            r_write_enable <= 1'b0;
            r_address      <= '0;
            r_input_data   <= '0;
        end else begin
            r_ram_enable   <= w_accept;
            r_write_enable <= w_accept & req_write;
            if (w_accept) begin
                r_address <= req_address;
            end
            if (w_accept && req_write) begin
                r_input_data <= req_data;
            end
        end
    end

    // Bit 0 marks a read on the pins; bit READ_LATENCY marks output_data ready for capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[READ_LATENCY-1:0], w_rd_accept};
        end
    end

    // Credits cover reads both in flight and parked in the FIFO, so the FIFO cannot overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_credit <= '0;
        end else begin
            assert (w_fifo_count <= r_credit);
            case ({w_rd_accept, w_pop})
                2'b10:   r_credit <= r_credit + CRED_W'(1);
                2'b01:   r_credit <= r_credit - CRED_W'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    bram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_capture),
        .i_push_data (output_data),
        .i_pop       (w_pop),
        .o_head_c    (rsp_data),
        .o_valid_c   (rsp_valid),
        .o_count     (w_fifo_count)
    );

endmodule

// File: doc/bram_port_master.md
Name: bram_port_master

Overview:
- Initiator side of the single-port Bram interface (clock, ram_enable, write_enable, address, input_data, output_data).
- Converts a valid/ready request stream (read or write) into registered Bram pin activity.
- Returns read data on a valid/ready response stream, preserving order.
- Sits between any client (loader, CPU-side bus bridge) and a Bram instance. Gives the client backpressure, which the raw Bram port lacks.

Parameters:
- ADDR_WIDTH, 9, Bram word-address width
- DATA_WIDTH, 32, Bram data width
- READ_LATENCY, 1, cycles from Bram sampling a read to output_data being valid
- RSP_DEPTH, 4, response FIFO entries and read-credit limit; power of two, >= 2

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at rising edge
- req_write  in  1  1 = write, 0 = read
- req_address  in  ADDR_WIDTH  word address
- req_data  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  client takes rsp_data when rsp_valid & rsp_ready
- rsp_data  out  DATA_WIDTH  read data, in request order
- ram_enable  out  1  to Bram ram_enable
- write_enable  out  1  to Bram write_enable
- address  out  ADDR_WIDTH  to Bram address
- input_data  out  DATA_WIDTH  to Bram input_data
- output_data  in  DATA_WIDTH  from Bram output_data

Behaviour:
- Reset (synchronous, active-high):
  - Clears the issue register, read-tag pipeline, FIFO and credit counter.
  - Forces ram_enable=0, write_enable=0, address=0, input_data=0, rsp_valid=0, rsp_data=0, req_ready=0.
  - Reads in flight at reset are discarded and never produce a response.
  - req_ready=1 from the first cycle after reset deasserts.
- Issue stage:
  - An accepted request in cycle N loads the Bram output registers.
  - During N+1: ram_enable=1, write_enable=req_write, address=req_address, input_data=req_data (read: input_data holds its previous value).
  - With no accept, ram_enable=0 and write_enable=0 next cycle. Throughput is one request per cycle.
- Read tag pipeline:
  - A read issued in N+1 shifts a valid bit through READ_LATENCY stages.
  - output_data is captured into the response FIFO at the end of cycle N+1+READ_LATENCY.
  - With READ_LATENCY=1: FIFO write at end of N+2, rsp_valid at earliest in N+3.
  - Writes produce no response.
- Credits:
  - credit_count = reads accepted but not yet popped from the FIFO.
  - +1 on read accept; -1 on rsp_valid & rsp_ready; both in the same cycle leave it unchanged.
  - req_ready = ~reset & (credit_count < RSP_DEPTH), from registered state only. No combinational path from req_write, req_valid or rsp_ready.
  - Writes use the same req_ready and consume no credit.
  - The FIFO therefore can never overflow. Overflow is an assertion failure.
- Response FIFO:
  - Synchronous, first-word-fall-through; rsp_data is valid whenever rsp_valid is high.
  - rsp_data and rsp_valid are stable while rsp_valid & ~rsp_ready.
  - A capture and a pop in the same cycle are both honoured.
- Ordering:
  - Bram pin order equals acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data.
- Address: no arithmetic; full ADDR_WIDTH range 0x000–0x1FF is valid.

Decomposition:
- Package bram_pkg:
  - BRAM_ADDR_WIDTH=9, BRAM_DATA_WIDTH=32, BRAM_READ_LATENCY=1.
  - Request struct type {write, address, data}.
  - Shared with Bram and its testbenches.
- One sub-module: bram_rsp_fifo, a parameterised sync FWFT FIFO (DATA_WIDTH, RSP_DEPTH) with push/pop/count and overflow/underflow assertions.
- Issue register, tag pipeline and credit counter live in the top module.

Test Plan:
1. Write 0xDEADBEEF to 0x005, then read 0x005, rsp_ready=1 -> ram_enable/write_enable=1/1 then 1/0 on consecutive cycles; rsp_data=0xDEADBEEF, rsp_valid 3 cycles after read accept.
2. Preload addr k with 0x1000+k; back-to-back reads 0..7, rsp_ready=1 -> req_ready never drops; rsp 0x1000..0x1007, one per cycle, in order.
3. rsp_ready=0, stream reads -> exactly 4 accepted, then req_ready=0. rsp_data is held stable. Raise rsp_ready for 1 cycle -> req_ready=1 the next cycle, one more read accepted.
4. Write 0xAAAA5555 to 0x1FF and 0x12345678 to 0x000, read both -> distinct correct values, no aliasing.
5. Issue 2 reads, assert reset for 1 cycle before their capture -> rsp_valid=0, ram_enable=0 the next cycle; no response ever appears; req_ready=1 after reset releases.
6. Mixed write/read alternation to the same address with random rsp_ready -> each read returns the most recent prior write; credit_count returns to 0 when idle.
